// File: rtl/inv_mixrow_serial_if.sv
// Handshake bundle for the row-serial inverse MixRow stage.
// Both the state input and the result output travel on this interface.
interface inv_mixrow_serial_if;
    logic                 in_valid;
    logic                 in_ready;
    logic [0:3][0:3][3:0] st_invmix;
    logic                 out_valid;
    logic                 out_ready;
    logic [0:3][0:3][3:0] invmix_state;
    logic                 busy;

    modport slave (
        input  in_valid,
        input  st_invmix,
        input  out_ready,
        output in_ready,
        output out_valid,
        output invmix_state,
        output busy
    );

    modport master (
        output in_valid,
        output st_invmix,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  invmix_state,
        input  busy
    );
endinterface

// File: rtl/inv_mixrow_serial.sv
// LOONG decryption MixRow: involutory 4x4 matrix over GF(2^4)/0x13,
// one result row per cycle.
module inv_mixrow_serial (
    input  logic               clock,
    input  logic               rst,
    inv_mixrow_serial_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [0:3][0:3][3:0] M = 64'h149D_41D9_9D14_D941;

    state_t               state;
    logic [1:0]           rc;
    logic [0:3][0:3][3:0] in_buf;
    logic [0:3][3:0]      row_res;

    // Shift-and-add multiply, reducing by x^4+x+1 as bit 3 falls off.
    function automatic logic [3:0] gmul(
        input logic [3:0] a,
        input logic [3:0] b
    );
        logic [3:0] p;
        logic [3:0] x;
        logic       hi;
        p = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[3];
            x  = {x[2:0], 1'b0};
            if (hi) x = x ^ 4'h3;
        end
        return p;
    endfunction

    always_comb begin
        row_res = '0;
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 4; l++) begin
                row_res[k] = row_res[k]
                           ^ gmul(in_buf[rc][l], M[l][k]);
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            rc               <= 2'd0;
            in_buf           <= '0;
            bus.invmix_state <= '0;
            bus.in_ready     <= 1'b1;
            bus.out_valid    <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_buf       <= bus.st_invmix;
                        rc           <= 2'd0;
                        state        <= CALC;
                        bus.in_ready <= 1'b0;
                        bus.busy     <= 1'b1;
                    end
                end
                CALC: begin
                    bus.invmix_state[rc] <= row_res;
                    rc                   <= rc + 2'd1;
                    if (rc == 2'd3) begin
                        state         <= DONE;
                        bus.out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        bus.in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.out_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                    bus.in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/inv_mixrow_serial.md
# inv_mixrow_serial

Decryption-side MixRow stage for the LOONG datapath. It takes a 4x4 nibble state over a valid/ready handshake and multiplies each state row by the 4x4 MixRow matrix over GF(2^4). Because that matrix is involutory (M·M = I), applying it again undoes the encryption-side MixRow. The block is row-serial: one output row per cycle, a 4-entry result buffer, and a held output handshake. It sits between the inverse key-add and inverse S-box stages of the decryption round.

## Interface
- Parameters: none. Matrix coefficients and the field polynomial are fixed (see Operation).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `st_invmix` holds a valid state.
- `in_ready`  out  1  block can accept a state this cycle.
- `st_invmix`  in  4 x [0:3][0:3]  input state, indexed `[row][col]`.
- `out_valid`  out  1  `invmix_state` holds a complete result.
- `out_ready`  in  1  downstream accepts the result.
- `invmix_state`  out  4 x [0:3][0:3]  result state, indexed `[row][col]`.
- `busy`  out  1  high in CALC or DONE.

## Operation
- **Field:** GF(2^4) with reduction polynomial x^4+x+1 (0x13). `gmul(a,b)` is shift-and-add over 4 iterations. When the shifted operand's bit 3 is set before a shift, XOR 0x3 after the shift (keeping 4 bits). Every intermediate value is 4 bits wide. Field addition is XOR.
- **Matrix M (rows):** (1,4,9,13), (4,1,13,9), (9,13,1,4), (13,9,4,1).
- **Output equation:** `out[r][k] = XOR over l of gmul(s[r][l], M[l][k])`.
- **State machine:** IDLE, CALC, DONE.
  - IDLE: `in_ready`=1. On `in_valid`&&`in_ready`, capture the whole `st_invmix` into an internal buffer, set row counter `rc`=0, go to CALC.
  - CALC: `in_ready`=0. Each cycle, compute all 4 columns of row `rc` from the buffer and write them to `invmix_state[rc]`. Then increment `rc`. If `rc`==3, go to DONE.
  - DONE: `out_valid`=1, `invmix_state` is stable. On `out_ready`=1, go to IDLE.
- **Unaccepted inputs:** `in_valid` in CALC or DONE is ignored. The source must hold it until `in_ready`; the input is never latched twice.
- **Output stability:** `invmix_state` rows not yet written in CALC keep their previous values. The output is only meaningful while `out_valid`=1.
- **Reset (`rst`=0, at any time, including mid-CALC or in DONE):**
  - state goes to IDLE and `rc` to 0;
  - `out_valid`=0, `busy`=0;
  - all `invmix_state` nibbles and the input buffer go to 0;
  - `in_ready`=1 once reset is released.
- **No partial results:** a reset in CALC discards the partial result, and no `out_valid` pulse follows.

## Timing
- Input accepted at edge N.
- Rows 0..3 are written at edges N+1..N+4.
- `out_valid` rises after edge N+4, giving a latency of 4 cycles from accept to valid.
- With `out_ready` held high, DONE lasts exactly 1 cycle. The state returns to IDLE at edge N+5, and the next accept is possible at edge N+6. Minimum throughput is one state per 6 cycles.
- `out_ready` low in DONE: hold `out_valid` and data indefinitely.
- `in_ready` and `out_valid` are never high in the same cycle.
- `in_ready` and `out_valid` are registered-state decodes only, with no combinational path from `in_valid` or `out_ready`.

## Test plan
- **Reset values:** assert `rst`=0 mid-stream. Require `out_valid`=0, `busy`=0, `in_ready`=1, all `invmix_state` = 0. After release, require no spurious `out_valid`.
- **Unit rows:** state rows (1,0,0,0), (0,1,0,0), (2,0,0,0), (1,1,0,0). Require result rows (1,4,9,13), (4,1,13,9), (2,8,1,9), (5,5,4,4), with `out_valid` exactly 4 cycles after accept.
- **Involution:** random states, each fed twice through the block. Require the second result to equal the original input. Also compare each result against a reference model using GF(2^4)/0x13, over 1000 vectors.
- **Backpressure:** hold `out_ready`=0 for 10 cycles in DONE while `in_valid`=1 with a new state. Require the output to be held, `in_ready`=0, and the new state not latched. Release `out_ready`, then require the new state to be accepted and produce its own correct result.
- **Reset mid-CALC:** assert `rst` on the cycle after row 1 is written. Require IDLE, all outputs cleared, and no `out_valid`. The next state then processes correctly.
- **Back-to-back:** `in_valid` and `out_ready` held high with 8 states. Require accepts every 6 cycles, results in order, all correct.
